// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg: scan FSM state codes, hex glyph table and polarity helper
package seg7_scan_ctrl_pkg;
  typedef enum logic {S_BLANK, S_ON} state_t;
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [6:0] pol7(input logic [6:0] v, input bit act_low);
    return act_low ? ~v : v;
  endfunction
endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// hex_to_seg7: nibble to active-high {g..a} segment pattern
module hex_to_seg7
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = GLYPH[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with dead time and frame-aligned data loads
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit AN_ACT_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [7*NUM_DIGITS-1:0] raw_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    raw_mode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACT_LOW ? '1 : '0;
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] hex;
    logic [7*NUM_DIGITS-1:0] raw;
    logic [NUM_DIGITS-1:0]   dpv;
    logic [NUM_DIGITS-1:0]   en;
    logic                    mode;
  } disp_t;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  pending;
  disp_t                 in_d, hold, disp;
  logic                  blank_end, dwell_end, wrap, lit;
  logic [6:0]            glyph, pattern;
  logic [NUM_DIGITS-1:0] onehot;
  assign in_d      = {hex_in, raw_in, dp_in, digit_en, raw_mode};
  assign blank_end = state == S_BLANK && cnt == CW'(BLANK_CYCLES - 1);
  assign dwell_end = state == S_ON && cnt == CW'(DWELL_CYCLES - 1);
  assign wrap      = dwell_end && idx == IW'(NUM_DIGITS - 1);
  assign lit       = state == S_ON && disp.en[idx];
  assign pattern   = disp.mode ? disp.raw[int'(idx)*7 +: 7] : glyph;
  assign onehot    = {{(NUM_DIGITS-1){1'b0}}, lit} << idx;
  hex_to_seg7 u_dec (
    .nib(disp.hex[{idx, 2'b00} +: 4]),
    .seg(glyph)
  );
  // The frame_done cycle is the frame boundary: the display registers swap
  // there, before the first digit slot of the new frame reaches the pins.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_BLANK;
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      hold       <= '0;
      disp       <= '0;
      an         <= AN_OFF;
      seg        <= pol7(7'h00, SEG_ACT_LOW);
      dp         <= SEG_ACT_LOW;
      frame_done <= 1'b0;
    end else begin
      cnt        <= (blank_end || dwell_end) ? '0 : cnt + 1'b1;
      state      <= blank_end ? S_ON : dwell_end ? S_BLANK : state;
      idx        <= !dwell_end ? idx : wrap ? '0 : idx + 1'b1;
      frame_done <= wrap;
      if (load) begin
        hold    <= in_d;
        pending <= 1'b1;
      end
      if (frame_done) begin
        disp    <= load ? in_d : pending ? hold : disp;
        pending <= 1'b0;
      end
      an  <= AN_ACT_LOW ? ~onehot : onehot;
      seg <= pol7(lit ? pattern : 7'h00, SEG_ACT_LOW);
      dp  <= SEG_ACT_LOW ^ (lit & disp.dpv[idx]);
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed plus randomized scan checks against a time-based display model
module tb_seg7_scan_ctrl;
  localparam int N = 4, DW = 4, BL = 1, SLOT = DW + BL, FRAME = N * SLOT;
  localparam logic [6:0] GL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef struct packed {
    logic [15:0] hex;
    logic [27:0] raw;
    logic [3:0]  dpv;
    logic [3:0]  en;
    logic        mode;
  } data_t;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  data_t in_d = '0, disp_m = '0, hold_m = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic dp, frame_done;
  int k = 0, checks = 0, passed = 0;
  seg7_scan_ctrl #(
    .NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .hex_in(in_d.hex), .raw_in(in_d.raw), .dp_in(in_d.dpv), .digit_en(in_d.en), .raw_mode(in_d.mode),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s k=%0d got %h exp %h", tag, k, got, exp);
  endtask
  function automatic logic [6:0] glyph(input data_t m, input int d);
    return m.mode ? m.raw[d*7 +: 7] : GL[m.hex[d*4 +: 4]];
  endfunction
  // Pins after edge k show the slot position of edge k-1; data swaps one edge after each frame end.
  task automatic step(input logic lv);
    int p, d;
    logic on_slot;
    logic [3:0] ea;
    load = lv;
    @(posedge clk);
    #1;
    k++;
    p = (k - 1) % FRAME;
    d = p / SLOT;
    on_slot = (p % SLOT) >= BL && disp_m.en[d];
    ea = on_slot ? ~(4'b0001 << d) : 4'hF;
    chk("an", 7'(an), 7'(ea));
    chk("seg", seg, on_slot ? ~glyph(disp_m, d) : 7'h7F);
    chk("dp", 7'(dp), 7'(!(on_slot && disp_m.dpv[d])));
    chk("frame_done", 7'(frame_done), 7'(k % FRAME == 0));
    if ((k - 1) % FRAME == 0 && k > 1) disp_m = lv ? in_d : hold_m;
    if (lv) hold_m = in_d;
    load = 1'b0;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask
  task automatic chk_dark(input string tag);
    chk({tag, "_an"}, 7'(an), 7'h0F);
    chk({tag, "_seg"}, seg, 7'h7F);
    chk({tag, "_dp"}, 7'(dp), 7'd1);
    chk({tag, "_fd"}, 7'(frame_done), 7'd0);
  endtask
  task automatic randomize_in();
    logic [31:0] r;
    r = $urandom();
    in_d.hex = r[15:0];
    r = $urandom();
    in_d.raw = r[27:0];
    r = $urandom();
    in_d.dpv = r[3:0];
    in_d.en = r[7:4];
    in_d.mode = r[8];
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_dark("reset");
    @(negedge clk);
    rst_n = 1'b1;
    in_d = '{hex: 16'h3210, raw: '0, dpv: 4'b0000, en: 4'hF, mode: 1'b0};
    step(1'b1);
    run(48);
    in_d.hex = 16'hFFFF;
    in_d.dpv = 4'b1010;
    step(1'b1);
    run(40);
    in_d = '{hex: 16'h0000, raw: 28'h0000049, dpv: 4'b0001, en: 4'b0101, mode: 1'b1};
    in_d.raw[20:14] = 7'h12;
    step(1'b1);
    run(45);
    for (int i = 0; i < FRAME && k % FRAME != 0; i++) step(1'b0);
    in_d = '{hex: 16'h9A5C, raw: '0, dpv: 4'b0100, en: 4'hF, mode: 1'b0};
    step(1'b1);
    run(25);
    for (int i = 0; i < 400; i++) begin
      randomize_in();
      step($urandom_range(0, 7) == 0);
    end
    in_d = '{hex: 16'h7E4B, raw: '0, dpv: 4'b1111, en: 4'hF, mode: 1'b0};
    step(1'b1);
    run(22);
    for (int i = 0; i < 40 && an == 4'hF; i++) step(1'b0);
    chk("lit_before_reset", 7'(an != 4'hF), 7'd1);
    #2 rst_n = 1'b0;
    #1 chk_dark("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    disp_m = '0;
    hold_m = '0;
    in_d = '{hex: 16'hD8E1, raw: '0, dpv: 4'b0010, en: 4'b1011, mode: 1'b0};
    step(1'b1);
    run(45);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
